// File: rtl/mem_rmw_pkg.sv
// Shared types and constants for the mem_rmw read-modify-write memory adapter.
// Define MEM_RMW_SIGNEXT_EN to sign-extend byte loads in byte_lane.
package mem_rmw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    // Memory is word organised, so the low two address bits never reach it.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_rmw_byte_lane.sv
// Combinational byte-lane helper: extracts/extends a load byte and merges a store byte.
// With MEM_RMW_SIGNEXT_EN defined, extracted bytes are sign-extended instead of zero-extended.
module byte_lane
    import mem_rmw_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [7:0]  new_byte,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [7:0] sel_byte;

    // Little-endian lanes: lane 0 is bits 7:0, lane 3 is bits 31:24.
    always_comb begin
        sel_byte = rd_word[7:0];
        merged   = rd_word;
        case (lane)
            LANE_B0: begin
                sel_byte     = rd_word[7:0];
                merged[7:0]  = new_byte;
            end
            LANE_B1: begin
                sel_byte     = rd_word[15:8];
                merged[15:8] = new_byte;
            end
            LANE_B2: begin
                sel_byte      = rd_word[23:16];
                merged[23:16] = new_byte;
            end
            LANE_B3: begin
                sel_byte      = rd_word[31:24];
                merged[31:24] = new_byte;
            end
            default: begin
                sel_byte = rd_word[7:0];
                merged   = rd_word;
            end
        endcase
    end

`ifdef MEM_RMW_SIGNEXT_EN
    assign load_ext = {{24{sel_byte[7]}}, sel_byte};
`else
    assign load_ext = {24'd0, sel_byte};
`endif

endmodule

// File: rtl/mem_rmw.sv
// CPU-to-word-memory adapter: word/byte loads and stores, byte stores done as read-modify-write.
// Optional MEM_RMW_SIGNEXT_EN (see byte_lane) selects sign-extended byte loads.
module mem_rmw
    import mem_rmw_pkg::*;
#(
    parameter int READ_LAT = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr_read,
    output logic [31:0] mem_addr_write,
    output logic        mem_en_write,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_out,
    input  logic        mem_ready
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  lat_cnt;
    logic [31:0] addr_q;
    logic [7:0]  byte_data_q;
    logic [31:0] wr_word_q;
    logic [31:0] rdata_q;
    logic        write_q;
    logic        byte_q;
    logic        accept;
    logic        sample;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Accepting only touches internal registers, so it does not wait for mem_ready.
    assign accept = req_valid && (state == IDLE);
    assign sample = (state == RD_WAIT) && mem_ready && (lat_cnt == LAT_LAST);

    assign mem_addr_read  = word_addr(addr_q);
    assign mem_addr_write = word_addr(addr_q);
    assign mem_data_write = wr_word_q;
    assign resp_rdata     = rdata_q;

    byte_lane u_byte_lane (
        .rd_word  (mem_out),
        .lane     (addr_q[1:0]),
        .new_byte (byte_data_q),
        .load_ext (load_ext),
        .merged   (merged)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are decoded from state and gated by mem_ready, so reset kills them instantly.
    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_en_write = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = (req_write && !req_byte) ? WRITE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sample) begin
                    next_state = write_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    mem_en_write = 1'b1;
                    resp_valid   = 1'b1;
                    next_state   = IDLE;
                end
            end
            RESP: begin
                if (mem_ready) begin
                    resp_valid = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            byte_data_q <= '0;
            wr_word_q   <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q      <= req_addr;
                byte_data_q <= req_wdata[7:0];
                write_q     <= req_write;
                byte_q      <= req_byte;
                lat_cnt     <= '0;
                if (req_write && !req_byte) begin
                    wr_word_q <= req_wdata;
                end
            end
            if ((state == RD_WAIT) && mem_ready && !sample) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            // Store results leave rdata_q untouched so the last load result stays visible.
            if (sample) begin
                if (write_q) begin
                    wr_word_q <= merged;
                end else begin
                    rdata_q <= byte_q ? load_ext : mem_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rmw.sv
// Self-checking bench for mem_rmw: vector table plus scoreboard, stall and reset sequences.
// Expected byte-load values follow MEM_RMW_SIGNEXT_EN when it is defined.
module tb_mem_rmw;

    localparam int READ_LAT = 1;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr_read;
    logic [31:0] mem_addr_write;
    logic        mem_en_write;
    logic [31:0] mem_data_write;
    logic [31:0] mem_out;
    logic        mem_ready;

    typedef struct {
        logic        wr;
        logic        by;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] data;
        int          lat;
    } exp_t;

    localparam int NVEC = 11;
    vec_t        vecs [NVEC];
    exp_t        exp_q [$];
    logic [31:0] mem [0:63];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          acc_cyc = 0;

    mem_rmw #(.READ_LAT(READ_LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_addr_read  (mem_addr_read),
        .mem_addr_write (mem_addr_write),
        .mem_en_write   (mem_en_write),
        .mem_data_write (mem_data_write),
        .mem_out        (mem_out),
        .mem_ready      (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory with combinational read; the address is held for the whole wait.
    assign mem_out = mem[mem_addr_read[7:2]];
    always @(posedge clock) begin
        if (mem_en_write) mem[mem_addr_write[7:2]] <= mem_data_write;
    end

    always @(posedge clock) begin
        if (req_valid && req_ready) acc_cyc = cyc;
        cyc = cyc + 1;
    end

    function automatic logic [31:0] ext8(input logic [7:0] b);
`ifdef MEM_RMW_SIGNEXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'd0, b};
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    task automatic fail_line(input string name);
        total_cnt++;
        $display("[TB] FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every response and checks stall/write rules.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (!mem_ready) check_output("write_while_stalled", {31'd0, mem_en_write}, 32'd0);
            if (mem_en_write && !resp_valid) fail_line("write_without_resp");
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_line("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check_output("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    if (e.wr) begin
                        check_output("wr_en", {31'd0, mem_en_write}, 32'd1);
                        check_output("wr_addr", mem_addr_write, e.waddr);
                        check_output("wr_data", mem_data_write, e.data);
                    end else begin
                        check_output("rd_data", resp_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic wr, input logic by, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] expv, input int stall);
        exp_t e;
        check_output("ready_at_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = by;
        req_addr  = addr;
        req_wdata = wdata;
        e.wr    = wr;
        e.waddr = {addr[31:2], 2'b00};
        e.data  = expv;
        e.lat   = ((wr && !by) ? 1 : 1 + READ_LAT) + stall;
        exp_q.push_back(e);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_line("resp_timeout");
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 32'h22, 32'h000000AA, 32'h11223344, 32'h11AA3344};
        vecs[2]  = '{1'b0, 1'b1, 32'h23, 32'h0,        32'h80FF0000, ext8(8'h80)};
        vecs[3]  = '{1'b0, 1'b0, 32'h33, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vecs[4]  = '{1'b0, 1'b1, 32'h40, 32'h0,        32'h12345678, ext8(8'h78)};
        vecs[5]  = '{1'b0, 1'b1, 32'h41, 32'h0,        32'h12345678, ext8(8'h56)};
        vecs[6]  = '{1'b1, 1'b1, 32'h50, 32'hFFFFFF55, 32'hAABBCCDD, 32'hAABBCC55};
        vecs[7]  = '{1'b1, 1'b1, 32'h57, 32'h00000011, 32'hAABBCCDD, 32'h11BBCCDD};
        vecs[8]  = '{1'b1, 1'b0, 32'h63, 32'h01020304, 32'h0,        32'h01020304};
        vecs[9]  = '{1'b0, 1'b1, 32'h6A, 32'h0,        32'h00C30000, ext8(8'hC3)};
        vecs[10] = '{1'b0, 1'b1, 32'h6D, 32'h0,        32'h00007F00, ext8(8'h7F)};

        repeat (2) @(posedge clock);
        #1;
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_mem_en_write", {31'd0, mem_en_write}, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_addr_read", mem_addr_read, 32'd0);
        check_output("rst_addr_write", mem_addr_write, 32'd0);
        check_output("rst_data_write", mem_data_write, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < NVEC; i++) begin
            mem[vecs[i].addr[7:2]] = vecs[i].init;
            apply_stimulus(vecs[i].wr, vecs[i].by, vecs[i].addr, vecs[i].wdata, vecs[i].expv, 0);
            wait_resp(20);
            if (vecs[i].wr) check_output("mem_contents", mem[vecs[i].addr[7:2]], vecs[i].expv);
        end

        // Store after a load must leave the previous load result on resp_rdata.
        apply_stimulus(1'b1, 1'b0, 32'h70, 32'h55667788, 32'h55667788, 0);
        wait_resp(20);
        check_output("rdata_hold", resp_rdata, ext8(8'h7F));

        // Word store issued while memory is stalled for two cycles after accept.
        mem_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h80, 32'h0BADC0DE, 32'h0BADC0DE, 2);
        @(posedge clock); #1;
        @(posedge clock); #1;
        mem_ready = 1'b1;
        wait_resp(20);
        check_output("stall_store_mem", mem[32'h80 >> 2], 32'h0BADC0DE);

        // Load stalled for three cycles, with a request pulsed while busy.
        mem[32'h90 >> 2] = 32'h13579BDF;
        apply_stimulus(1'b0, 1'b0, 32'h90, 32'h0, 32'h13579BDF, 3);
        mem_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 32'hA0; req_wdata = 32'hFEEDFACE;
        check_output("busy_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        mem_ready = 1'b1;
        wait_resp(20);
        repeat (4) begin
            @(posedge clock); #1;
        end
        check_output("ignored_req", mem[32'hA0 >> 2], 32'h0);

        // Reset during the read phase of a byte store.
        mem[32'hB0 >> 2] = 32'h11223344;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
        req_addr = 32'hB1; req_wdata = 32'h000000EE;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check_output("busy_before_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_output("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("abort_mem_en_write", {31'd0, mem_en_write}, 32'd0);
        check_output("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("abort_data_write", mem_data_write, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check_output("no_partial_write", mem[32'hB0 >> 2], 32'h11223344);

        apply_stimulus(1'b0, 1'b1, 32'hB1, 32'h0, ext8(8'h33), 0);
        wait_resp(20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
